// File: rtl/dp_microseq_if.sv
// Host-side micro-op push channel for dp_microseq.
interface dp_microseq_if;
  logic        UOP_VALID;
  logic        UOP_READY;
  logic [15:0] UOP_CW;
  logic [2:0]  UOP_COND;
  logic [15:0] UOP_DATA;

  modport master (
    output UOP_VALID,
    output UOP_CW,
    output UOP_COND,
    output UOP_DATA,
    input  UOP_READY
  );

  modport slave (
    input  UOP_VALID,
    input  UOP_CW,
    input  UOP_COND,
    input  UOP_DATA,
    output UOP_READY
  );
endinterface

// File: rtl/dp_microseq.sv
// Control-word sequencer for the 16-bit register-file datapath.
// A host pushes {cond, control word, data} micro-ops into a FIFO; one op is
// issued per clock with its condition evaluated against the datapath flags.
// Optional single-step mode: define DP_MICROSEQ_STEP_EN to add the STEP input.
module dp_microseq #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        CLK,
  input  logic        RESET,
  dp_microseq_if.slave uop,
  input  logic        RESUME,
`ifdef DP_MICROSEQ_STEP_EN
  input  logic        STEP,
`endif
  input  logic        V,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  output logic [15:0] CTRWRD,
  output logic [15:0] Din,
  output logic [15:0] Cin,
  output logic [3:0]  FLAGS,
  output logic        HALTED,
  output logic [15:0] ISSUE_CNT
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW-1:0] PtrOne = AW'(1);
  localparam logic [AW:0]   CntOne = (AW+1)'(1);
  localparam logic [AW:0]   CntFull = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StHalt} state_e;

  // FIFO storage: {cond[2:0], cw[15:0], data[15:0]}
  logic [34:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   fcnt_q, fcnt_d;
  logic          full, empty, push, pop;

  logic [2:0]  head_cond;
  logic [15:0] head_cw;
  logic [15:0] head_data;

  state_e state_q, state_d;

  logic [15:0] ctrwrd_q, ctrwrd_d;
  logic [15:0] din_q, din_d;
  logic [3:0]  flags_q, flags_d;
  logic        halted_q, halted_d;
  logic [15:0] issue_q, issue_d;
  // Currently driven word is an executed (non-squashed) op.
  logic        exec_q, exec_d;

  logic [3:0]  eff_flags;
  logic        cond_true;
  logic        pop_halt;

  assign full  = (fcnt_q == CntFull);
  assign empty = (fcnt_q == '0);
  assign uop.UOP_READY = ~full;
  assign push  = uop.UOP_VALID & ~full;

  assign head_cond = mem_q[rptr_q][34:32];
  assign head_cw   = mem_q[rptr_q][31:16];
  assign head_data = mem_q[rptr_q][15:0];

`ifdef DP_MICROSEQ_STEP_EN
  assign pop       = (state_q == StIssue) & ~empty & STEP;
  assign eff_flags = flags_q;
`else
  assign pop       = (state_q == StIssue) & ~empty;
  // Forward live flags behind an executed op so dependent ops need no bubble.
  assign eff_flags = exec_q ? {V, C, N, Z} : flags_q;
`endif

  assign pop_halt = pop & (head_cond == 3'd7);

  // FIFO entry write; contents need no reset since pointers qualify them.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wptr_q] <= {uop.UOP_COND, uop.UOP_CW, uop.UOP_DATA};
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fcnt_d = fcnt_q;
    if (push) wptr_d = wptr_q + PtrOne;
    if (pop)  rptr_d = rptr_q + PtrOne;
    unique case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + CntOne;
      2'b01:   fcnt_d = fcnt_q - CntOne;
      default: fcnt_d = fcnt_q;
    endcase
  end

  // FIFO pointer registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Issue condition against the effective flags {V,C,N,Z}.
  always_comb begin
    cond_true = 1'b0;
    case (head_cond)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = eff_flags[0];
      3'd2:    cond_true = ~eff_flags[0];
      3'd3:    cond_true = eff_flags[1];
      3'd4:    cond_true = eff_flags[2];
      3'd5:    cond_true = eff_flags[3];
      default: cond_true = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: ISSUE whenever ops remain after this edge, unless halted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StIssue: begin
        if (pop_halt) begin
          state_d = StHalt;
        end else begin
          state_d = (fcnt_d != '0) ? StIssue : StIdle;
        end
      end
      StHalt: begin
        if (RESUME) state_d = (fcnt_d != '0) ? StIssue : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: next control word, data, flags and executed-op count.
  always_comb begin
    ctrwrd_d = NOP_WORD;
    din_d    = din_q;
    exec_d   = 1'b0;
    if (pop && !pop_halt) begin
      din_d    = head_data;
      exec_d   = cond_true;
      // Squashed ops still reach the datapath but with RW cleared.
      ctrwrd_d = cond_true ? head_cw : {head_cw[15:1], 1'b0};
    end
    flags_d  = exec_q ? {V, C, N, Z} : flags_q;
    issue_d  = exec_q ? issue_q + 16'd1 : issue_q;
    halted_d = (state_d == StHalt);
  end

  // Registered datapath-facing outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ctrwrd_q <= NOP_WORD;
      din_q    <= '0;
      flags_q  <= '0;
      halted_q <= 1'b0;
      issue_q  <= '0;
      exec_q   <= 1'b0;
    end else begin
      ctrwrd_q <= ctrwrd_d;
      din_q    <= din_d;
      flags_q  <= flags_d;
      halted_q <= halted_d;
      issue_q  <= issue_d;
      exec_q   <= exec_d;
    end
  end

  assign CTRWRD    = ctrwrd_q;
  assign Din       = din_q;
  assign Cin       = din_q;
  assign FLAGS     = flags_q;
  assign HALTED    = halted_q;
  assign ISSUE_CNT = issue_q;

endmodule

// File: tb/tb_dp_microseq.sv
// Directed bench for dp_microseq with a scoreboard of expected issued words.
module tb_dp_microseq;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        RESUME = 1'b0;
  logic        STEP = 1'b0;
  logic        vf = 1'b0, cf = 1'b0, nf = 1'b0, zf = 1'b0;
  logic        Z;
  logic [15:0] CTRWRD, Din, Cin, ISSUE_CNT;
  logic [3:0]  FLAGS;
  logic        HALTED;

  dp_microseq_if uop_if ();

  dp_microseq #(
    .DEPTH    (4),
    .NOP_WORD (16'h0000)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .uop       (uop_if.slave),
    .RESUME    (RESUME),
`ifdef DP_MICROSEQ_STEP_EN
    .STEP      (STEP),
`endif
    .V         (vf),
    .C         (cf),
    .N         (nf),
    .Z         (Z),
    .CTRWRD    (CTRWRD),
    .Din       (Din),
    .Cin       (Cin),
    .FLAGS     (FLAGS),
    .HALTED    (HALTED),
    .ISSUE_CNT (ISSUE_CNT)
  );

  always #5 CLK = ~CLK;

  // Datapath model: a subtract (FS=0101) of a register from itself gives zero.
  assign Z = zf | (CTRWRD[5:2] == 4'h5);

  typedef struct packed {
    logic [15:0] cw;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every non-NOP word reaching the datapath must match the scoreboard head.
  always @(negedge CLK) begin
    if (RESET && CTRWRD !== 16'h0000) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue", 32'(CTRWRD), 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("ctrwrd", 32'(CTRWRD), 32'(mon_e.cw));
        chk("din", 32'(Din), 32'(mon_e.data));
        chk("cin", 32'(Cin), 32'(mon_e.data));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [2:0] cond, input logic [15:0] cw, input logic [15:0] data,
                      input bit exp_on, input logic [15:0] exp_cw);
    exp_t e;
    int   n = 0;
    uop_if.UOP_VALID = 1'b1;
    uop_if.UOP_COND  = cond;
    uop_if.UOP_CW    = cw;
    uop_if.UOP_DATA  = data;
    while (!uop_if.UOP_READY && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("push_timeout", 32'(n), 32'h0);
    if (exp_on) begin
      e.cw   = exp_cw;
      e.data = data;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic idle();
    uop_if.UOP_VALID = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'(sb.size()), 32'h0);
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c;
    uop_if.UOP_VALID = 1'b0;
    uop_if.UOP_COND  = 3'd0;
    uop_if.UOP_CW    = 16'h0;
    uop_if.UOP_DATA  = 16'h0;
    #12;
    // Reset state
    chk("rst_ctrwrd", 32'(CTRWRD), 32'h0);
    chk("rst_din", 32'(Din), 32'h0);
    chk("rst_cin", 32'(Cin), 32'h0);
    chk("rst_flags", 32'(FLAGS), 32'h0);
    chk("rst_cnt", 32'(ISSUE_CNT), 32'h0);
    chk("rst_halted", 32'(HALTED), 32'h0);
    chk("rst_ready", 32'(uop_if.UOP_READY), 32'h1);
    @(negedge CLK);
    RESET = 1'b1;
    tick();

`ifdef DP_MICROSEQ_STEP_EN
    // Single-step: three ops queued, STEP pulsed twice, two issue.
    push(3'd0, 16'h2003, 16'h0011, 1'b1, 16'h2003);
    push(3'd0, 16'h4003, 16'h0022, 1'b1, 16'h4003);
    push(3'd0, 16'h6003, 16'h0033, 1'b0, 16'h0000);
    idle();
    tick();
    STEP = 1'b1; tick(); STEP = 1'b0;
    repeat (3) tick();
    STEP = 1'b1; tick(); STEP = 1'b0;
    repeat (4) tick();
    chk("step_cnt", 32'(ISSUE_CNT), 32'd2);
    chk("step_sb_empty", 32'(sb.size()), 32'h0);
    chk("step_ctrwrd_nop", 32'(CTRWRD), 32'h0);
`else
    // Eight register writes R0..R7 = 1..8
    for (int i = 0; i < 8; i++) begin
      c = (16'(i) << 13) | 16'h0003;
      push(3'd0, c, 16'(i + 1), 1'b1, c);
    end
    idle();
    drain();
    chk("cnt_after_8", 32'(ISSUE_CNT), 32'd8);
    chk("flags_after_8", 32'(FLAGS), 32'h0);

    // Zero-result subtract then COND=1 write, back to back (live Z forwarding)
    push(3'd0, 16'h6915, 16'h0000, 1'b1, 16'h6915);
    push(3'd1, 16'h2003, 16'hFFFF, 1'b1, 16'h2003);
    idle();
    drain();
    chk("cnt_z_exec", 32'(ISSUE_CNT), 32'd10);
    chk("flags_z_exec", 32'(FLAGS), 32'h0);

    // COND=2 variant squashes: RW cleared, no count, FLAGS hold
    push(3'd0, 16'h6915, 16'h0000, 1'b1, 16'h6915);
    push(3'd2, 16'h2003, 16'hFFFF, 1'b1, 16'h2002);
    idle();
    drain();
    chk("cnt_nz_squash", 32'(ISSUE_CNT), 32'd11);
    chk("flags_nz_squash", 32'(FLAGS), 32'h1);

    // Previous word not executed: condition uses registered FLAGS (Z=1)
    push(3'd1, 16'h4003, 16'h1234, 1'b1, 16'h4003);
    idle();
    drain();
    chk("cnt_flags_path", 32'(ISSUE_CNT), 32'd12);
    chk("flags_after_w2", 32'(FLAGS), 32'h0);

    // COND=6 never; COND=4 via live C; COND=5 squashed with V=0
    push(3'd6, 16'h6003, 16'h5555, 1'b1, 16'h6002);
    cf = 1'b1;
    push(3'd0, 16'h8003, 16'h0101, 1'b1, 16'h8003);
    push(3'd4, 16'hA003, 16'h0202, 1'b1, 16'hA003);
    push(3'd5, 16'hC003, 16'h0303, 1'b1, 16'hC002);
    idle();
    drain();
    cf = 1'b0;
    chk("cnt_cv", 32'(ISSUE_CNT), 32'd14);
    chk("flags_cv", 32'(FLAGS), 32'h4);

    // HALT with FIFO filling behind it
    push(3'd7, 16'h0007, 16'h0000, 1'b0, 16'h0000);
    push(3'd0, 16'h2403, 16'h0011, 1'b1, 16'h2403);
    push(3'd0, 16'h2803, 16'h0022, 1'b1, 16'h2803);
    push(3'd0, 16'h2C03, 16'h0033, 1'b1, 16'h2C03);
    push(3'd0, 16'h3003, 16'h0044, 1'b1, 16'h3003);
    idle();
    chk("full_ready", 32'(uop_if.UOP_READY), 32'h0);
    chk("halt_halted", 32'(HALTED), 32'h1);
    chk("halt_ctrwrd", 32'(CTRWRD), 32'h0);
    // Push while full is dropped
    uop_if.UOP_VALID = 1'b1;
    uop_if.UOP_COND  = 3'd0;
    uop_if.UOP_CW    = 16'h3403;
    uop_if.UOP_DATA  = 16'h0055;
    tick();
    idle();
    tick();
    chk("full_ready2", 32'(uop_if.UOP_READY), 32'h0);
    chk("halt_cnt", 32'(ISSUE_CNT), 32'd14);
    chk("halt_still", 32'(HALTED), 32'h1);
    RESUME = 1'b1;
    tick();
    RESUME = 1'b0;
    chk("resume_halted", 32'(HALTED), 32'h0);
    chk("resume_nop", 32'(CTRWRD), 32'h0);
    tick();
    chk("resume_first", 32'(CTRWRD), 32'h2403);
    drain();
    chk("cnt_after_halt", 32'(ISSUE_CNT), 32'd18);
    // RESUME outside HALT does nothing
    RESUME = 1'b1;
    tick();
    RESUME = 1'b0;
    tick();
    chk("resume_ignored", 32'(HALTED), 32'h0);
    chk("resume_ignored_w", 32'(CTRWRD), 32'h0);

    // Reset mid-stream with three ops still queued
    push(3'd7, 16'h0007, 16'h0000, 1'b0, 16'h0000);
    push(3'd0, 16'h2403, 16'h0A0A, 1'b1, 16'h2403);
    push(3'd0, 16'h2803, 16'h0B0B, 1'b1, 16'h2803);
    push(3'd0, 16'h2C03, 16'h0C0C, 1'b1, 16'h2C03);
    push(3'd0, 16'h3003, 16'h0D0D, 1'b1, 16'h3003);
    idle();
    tick();
    RESUME = 1'b1;
    tick();
    RESUME = 1'b0;
    tick();
    RESET = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_ctrwrd", 32'(CTRWRD), 32'h0);
    chk("mid_rst_cnt", 32'(ISSUE_CNT), 32'h0);
    chk("mid_rst_din", 32'(Din), 32'h0);
    chk("mid_rst_flags", 32'(FLAGS), 32'h0);
    chk("mid_rst_halted", 32'(HALTED), 32'h0);
    tick();
    #2;
    RESET = 1'b1;
    tick();
    chk("post_rst_ready", 32'(uop_if.UOP_READY), 32'h1);
    repeat (6) tick();
    chk("post_rst_cnt", 32'(ISSUE_CNT), 32'h0);
    chk("post_rst_ctrwrd", 32'(CTRWRD), 32'h0);

    // ISSUE_CNT wraps FFFF -> 0000
    for (int i = 0; i < 65535; i++) begin
      push(3'd0, 16'h0001, 16'h0000, 1'b1, 16'h0001);
    end
    idle();
    drain();
    chk("cnt_ffff", 32'(ISSUE_CNT), 32'hFFFF);
    push(3'd0, 16'h0001, 16'h0000, 1'b1, 16'h0001);
    idle();
    drain();
    chk("cnt_wrap", 32'(ISSUE_CNT), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
